trace_readback_ctrl: RTL and testbench



---
 rtl/trace_pkg.sv | 19 +
 rtl/trace_addr_wrap.sv | 18 +
 rtl/trace_readback_ctrl.sv | 177 +++++++++++++++++
 tb/tb_trace_readback_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the trace capture/readback blocks: DRAM port widths,
// capture region limit and the readback controller state encoding.
package trace_pkg;

  localparam int DRAM_ADDR_W = 24;
  localparam int DRAM_DATA_W = 32;

  // Last word address of the DRAM capture region (shared with the capture writer).
  localparam logic [DRAM_ADDR_W-1:0] CAPTURE_LIMIT_ADDR = 24'h5FFF01;

  typedef enum logic [2:0] {
    TRB_IDLE        = 3'd0,
    TRB_RD_HI       = 3'd1,
    TRB_RD_LO_START = 3'd2,
    TRB_RD_LO       = 3'd3,
    TRB_OUT         = 3'd4
  } trb_state_e;

endpackage

// File: rtl/trace_addr_wrap.sv
// Combinational word-pointer increment that wraps to 0 after the last word of
// the capture region. Shared by the capture writer and the readback controller.
module trace_addr_wrap
  import trace_pkg::*;
#(
  parameter logic [DRAM_ADDR_W-1:0] LIMIT_ADDR = CAPTURE_LIMIT_ADDR
) (
  input  logic [DRAM_ADDR_W-1:0] ptr,
  output logic [DRAM_ADDR_W-1:0] ptr_next
);

  // Wrap to the start of the region after LIMIT_ADDR, otherwise step by one word.
  always_comb begin
    if (ptr == LIMIT_ADDR) ptr_next = '0;
    else                   ptr_next = ptr + DRAM_ADDR_W'(1);
  end

endmodule

// File: rtl/trace_readback_ctrl.sv
// Trace readback controller: reads 64-bit samples (hi word, then lo word) from
// the DRAM capture region and streams them out over a valid/ready handshake.
// Optional build macro TRACE_RB_CHECKSUM_EN adds a running XOR checksum output.
module trace_readback_ctrl
  import trace_pkg::*;
#(
  parameter logic [DRAM_ADDR_W-1:0] LIMIT_ADDR = CAPTURE_LIMIT_ADDR,
  parameter int                     CNT_W      = 22
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [DRAM_ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]         sample_count,
  output logic                     busy,
  output logic                     done,
  output logic                     dram_req,
  input  logic                     dram_ack,
  output logic [DRAM_ADDR_W-1:0]   dram_addr,
  output logic                     dram_we,
  input  logic [DRAM_DATA_W-1:0]   dram_rdata,
  output logic [2*DRAM_DATA_W-1:0] sample_data,
  output logic                     sample_valid,
  input  logic                     sample_ready
`ifdef TRACE_RB_CHECKSUM_EN
  ,
  output logic [DRAM_DATA_W-1:0]   checksum
`endif
);

  trb_state_e                 state_q, state_d;
  logic [DRAM_ADDR_W-1:0]     ptr_q, ptr_d, ptr_next;
  logic [CNT_W-1:0]           rem_q, rem_d;
  logic [DRAM_DATA_W-1:0]     hi_q, hi_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       req_q, req_d;
  logic [DRAM_ADDR_W-1:0]     addr_q, addr_d;
  logic [2*DRAM_DATA_W-1:0]   data_q, data_d;
  logic                       valid_q, valid_d;
`ifdef TRACE_RB_CHECKSUM_EN
  logic [DRAM_DATA_W-1:0]     csum_q, csum_d;
`endif

  trace_addr_wrap #(
    .LIMIT_ADDR (LIMIT_ADDR)
  ) u_addr_wrap (
    .ptr      (ptr_q),
    .ptr_next (ptr_next)
  );

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
`ifdef TRACE_RB_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      TRB_IDLE: begin
        if (start) begin
`ifdef TRACE_RB_CHECKSUM_EN
          csum_d = '0;
`endif
          if (sample_count != '0) begin
            ptr_d   = base_addr;
            rem_d   = sample_count;
            busy_d  = 1'b1;
            req_d   = 1'b1;
            addr_d  = base_addr;
            state_d = TRB_RD_HI;
          end else begin
            // Empty transfer: report completion without touching DRAM.
            done_d = 1'b1;
          end
        end
      end
      TRB_RD_HI: begin
        if (dram_ack) begin
          hi_d    = dram_rdata;
          req_d   = 1'b0;
          addr_d  = '0;
          ptr_d   = ptr_next;
          state_d = TRB_RD_LO_START;
        end
      end
      TRB_RD_LO_START: begin
        // One forced req-low cycle separates the hi and lo word reads.
        req_d   = 1'b1;
        addr_d  = ptr_q;
        state_d = TRB_RD_LO;
      end
      TRB_RD_LO: begin
        if (dram_ack) begin
          data_d  = {hi_q, dram_rdata};
          valid_d = 1'b1;
          req_d   = 1'b0;
          addr_d  = '0;
          ptr_d   = ptr_next;
          rem_d   = rem_q - CNT_W'(1);
          state_d = TRB_OUT;
        end
      end
      TRB_OUT: begin
        if (valid_q && sample_ready) begin
          valid_d = 1'b0;
`ifdef TRACE_RB_CHECKSUM_EN
          csum_d  = csum_q ^ data_q[2*DRAM_DATA_W-1:DRAM_DATA_W] ^ data_q[DRAM_DATA_W-1:0];
`endif
          if (rem_q == '0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = TRB_IDLE;
          end else begin
            req_d   = 1'b1;
            addr_d  = ptr_q;
            state_d = TRB_RD_HI;
          end
        end
      end
      default: state_d = TRB_IDLE;
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TRB_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef TRACE_RB_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
`ifdef TRACE_RB_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign dram_req     = req_q;
  assign dram_addr    = addr_q;
  assign dram_we      = 1'b0;
  assign sample_data  = data_q;
  assign sample_valid = valid_q;
`ifdef TRACE_RB_CHECKSUM_EN
  assign checksum     = csum_q;
`endif

endmodule

// File: tb/tb_trace_readback_ctrl.sv
// Testbench for trace_readback_ctrl: directed and randomized transfers checked
// against a word-list model of the capture region.
module tb_trace_readback_ctrl;

  localparam longint REGION = 64'h5FFF02;  // words in the capture region

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] base_addr = '0;
  logic [21:0] sample_count = '0;
  logic        busy, done, dram_req, dram_we, sample_valid;
  logic        dram_ack = 1'b0;
  logic [23:0] dram_addr;
  logic [31:0] dram_rdata = '0;
  logic [63:0] sample_data;
  logic        sample_ready = 1'b0;
`ifdef TRACE_RB_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] dir_words[$];

  trace_readback_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .sample_count (sample_count),
    .busy         (busy),
    .done         (done),
    .dram_req     (dram_req),
    .dram_ack     (dram_ack),
    .dram_addr    (dram_addr),
    .dram_we      (dram_we),
    .dram_rdata   (dram_rdata),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready)
`ifdef TRACE_RB_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] wrap_add(input logic [23:0] b, input int k);
    longint s;
    s = (longint'(b) + longint'(k)) % REGION;
    return s[23:0];
  endfunction

  function automatic logic [23:0] rand_base();
    case ($urandom_range(0, 2))
      0:       return 24'($urandom_range(0, 32'h5FFF01));
      1:       return 24'(32'h5FFF01 - $urandom_range(0, 6));
      default: return 24'($urandom_range(0, 100));
    endcase
  endfunction

  // mode 0: ack at once, ready always; 1: random ack/ready/spurious ack/ignored start;
  // 2: ack at once, first sample stalled for 10 cycles.
  task automatic run_xfer(input logic [23:0] b, input int n, input int mode, input bit directed);
    logic [31:0] words[$];
    logic [23:0] addrs[$];
    logic [63:0] samples[$];
    logic [31:0] csum = '0;
    logic [63:0] held = '0;
    logic        prev_req = 0, prev_ack = 0, hi1 = 0, hi2 = 0, prev_lo = 0;
    logic        prev_hs_more = 0, prev_unacc = 0, done_seen = 0;
    logic        ack, ready, cur_hi, cur_lo;
    int          widx = 0, cyc = 0, stall_left = 10;

    for (int k = 0; k < 2 * n; k++) begin
      logic [31:0] w;
      w = directed ? dir_words[k] : $urandom;
      words.push_back(w);
      addrs.push_back(wrap_add(b, k));
      csum ^= w;
    end
    for (int i = 0; i < n; i++) samples.push_back({words[2*i], words[2*i+1]});

    @(negedge clk);
    base_addr = b; sample_count = 22'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_latency", dram_req, 1);

    while (!done_seen && cyc < 2000) begin
      if (done) begin
        chk("busy_at_done", busy, 0);
        chk("all_consumed", 64'(samples.size() + addrs.size()), 0);
`ifdef TRACE_RB_CHECKSUM_EN
        chk("checksum", checksum, csum);
`endif
        done_seen = 1;
      end else begin
        chk("busy", busy, 1);
      end
      if (!dram_req) chk("addr_idle_zero", dram_addr, 0);
      if (prev_ack) chk("req_gap_after_ack", dram_req, 0);
      if (hi2) chk("lo_req_after_gap", dram_req, 1);
      if (prev_lo) chk("valid_latency", sample_valid, 1);
      if (prev_hs_more) chk("next_req_latency", dram_req, 1);
      if (sample_valid) chk("no_req_while_valid", dram_req, 0);
      if (prev_unacc) chk("data_stable", sample_data, held);
      if (dram_req && !prev_req) begin
        if (addrs.size() == 0) chk("extra_req", 64'(addrs.size()), 1);
        else chk("dram_addr", dram_addr, addrs.pop_front());
      end

      ack = 1'b0;
      dram_rdata = $urandom;
      if (dram_req) ack = (mode == 1) ? ($urandom_range(0, 2) == 0) : 1'b1;
      else if (mode == 1) ack = ($urandom_range(0, 3) == 0);
      cur_hi = 0; cur_lo = 0;
      if (dram_req && ack) begin
        if (widx < words.size()) dram_rdata = words[widx];
        cur_hi = (widx % 2 == 0);
        cur_lo = (widx % 2 == 1);
        widx++;
      end

      case (mode)
        1: ready = ($urandom_range(0, 3) != 0);
        2: begin
          ready = 1'b1;
          if (sample_valid && stall_left > 0) begin ready = 1'b0; stall_left--; end
        end
        default: ready = 1'b1;
      endcase

      prev_hs_more = 0;
      if (sample_valid && ready) begin
        if (samples.size() == 0) chk("extra_sample", 64'(samples.size()), 1);
        else chk("sample_data", sample_data, samples.pop_front());
        prev_hs_more = (samples.size() != 0);
      end
      prev_unacc = sample_valid && !ready;
      held = sample_data;

      // A start while busy must be ignored (never during the done cycle: DUT is idle then).
      start = (mode == 1) && !done && ($urandom_range(0, 7) == 0);
      if (start) begin base_addr = 24'($urandom); sample_count = 22'($urandom_range(1, 5)); end

      hi2 = hi1; hi1 = cur_hi; prev_lo = cur_lo;
      prev_ack = dram_req && ack;
      prev_req = dram_req;
      dram_ack = ack;
      sample_ready = ready;
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    chk("transfer_completed", done_seen, 1);
    chk("done_one_cycle", done, 0);
    chk("idle_no_req", dram_req, 0);
    chk("idle_busy", busy, 0);
    dram_ack = 1'b0;
    sample_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", dram_req, 0);
    chk("rst_addr", dram_addr, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_data", sample_data, 0);
    chk("dram_we", dram_we, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed two-sample transfer
    dir_words = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004};
    run_xfer(24'h000010, 2, 0, 1'b1);

    // Zero-length transfer
    @(negedge clk);
    sample_count = '0; base_addr = 24'h123456; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_req", dram_req, 0);
    @(negedge clk);
    chk("zero_done_pulse", done, 0);
    chk("zero_req_after", dram_req, 0);

    // Wrap between hi and lo words
    run_xfer(24'h5FFF01, 1, 0, 1'b0);

    // Consumer stall on the first sample
    run_xfer(24'h000200, 2, 2, 1'b0);

    // Reset while the lo-word request is outstanding
    @(negedge clk);
    base_addr = 24'h000040; sample_count = 22'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int acks = 0;
      int cyc = 0;
      while (!(acks == 1 && dram_req) && cyc < 20) begin
        dram_ack = dram_req;
        dram_rdata = $urandom;
        if (dram_req) acks++;
        @(negedge clk);
        cyc++;
      end
      chk("reached_rd_lo", dram_req, 1);
      chk("rd_lo_addr", dram_addr, 24'h000041);
    end
    dram_ack = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", dram_req, 0);
    chk("mid_rst_addr", dram_addr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_valid", sample_valid, 0);
    chk("mid_rst_data", sample_data, 0);
`ifdef TRACE_RB_CHECKSUM_EN
    chk("mid_rst_checksum", checksum, 0);
`endif
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_quiet", {done, dram_req, busy}, 0);
    end
    run_xfer(rand_base(), 2, 0, 1'b0);

    // Randomized transfers with random ack delays, stalls and spurious inputs
    for (int r = 0; r < 10; r++) run_xfer(rand_base(), $urandom_range(1, 6), 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
